// File: rtl/regfile_sb_if.sv
// regfile_sb_if: read, write, issue and scoreboard signals of regfile_sb.
// The master drives addresses, writes and issues; the slave returns data and busy state.
interface regfile_sb_if #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int NUM_RD   = 3
);
    localparam int AW = $clog2(NUM_REGS);
    logic [NUM_RD*AW-1:0]     rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic                     we0;
    logic                     we1;
    logic [AW-1:0]            wa0;
    logic [AW-1:0]            wa1;
    logic [DATA_W-1:0]        wd0;
    logic [DATA_W-1:0]        wd1;
    logic                     iss_valid;
    logic [AW-1:0]            iss_reg;
    logic                     iss_ready;
    logic [NUM_REGS-1:0]      busy;
    modport master (
        output rd_addr, we0, we1, wa0, wa1, wd0, wd1, iss_valid, iss_reg,
        input  rd_data, rd_busy, iss_ready, busy
    );
    modport slave (
        input  rd_addr, we0, we1, wa0, wa1, wd0, wd1, iss_valid, iss_reg,
        output rd_data, rd_busy, iss_ready, busy
    );
endinterface

// File: rtl/regfile_sb.sv
// regfile_sb: 2-write, NUM_RD-read register file with a per-register pending-write scoreboard.
// Define REGFILE_SB_BYPASS_EN to forward same-cycle write data (and clear rd_busy) to the read ports.
module regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int NUM_RD   = 3
) (
    input logic         clk,
    input logic         rst_n,
    regfile_sb_if.slave bus
);
    localparam int AW = $clog2(NUM_REGS);
    logic [DATA_W-1:0]        regs [NUM_REGS];
    logic [NUM_REGS-1:0]      busy_q;
    logic [NUM_REGS-1:0]      busy_nxt;
    logic [NUM_RD*DATA_W-1:0] rd_data_c;
    logic [NUM_RD-1:0]        rd_busy_c;
    logic [AW-1:0]            ra;
    logic                     w0_ok;
    logic                     w1_ok;
    logic                     iss_ok;
    assign w0_ok = bus.we0 && bus.wa0 != '0;
    assign w1_ok = bus.we1 && bus.wa1 != '0;
    assign bus.iss_ready = bus.iss_valid && (bus.iss_reg == '0 || !busy_q[bus.iss_reg]);
    assign iss_ok = bus.iss_ready && bus.iss_reg != '0;
    // Clears first so a same-cycle issue to the written register keeps it pending.
    always_comb begin
        busy_nxt = busy_q;
        if (w0_ok) busy_nxt[bus.wa0] = 1'b0;
        if (w1_ok) busy_nxt[bus.wa1] = 1'b0;
        if (iss_ok) busy_nxt[bus.iss_reg] = 1'b1;
    end
    // Port 1 is written last so it wins a same-address collision; register 0 is never written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            busy_q <= '0;
        end else begin
            if (w0_ok) regs[bus.wa0] <= bus.wd0;
            if (w1_ok) regs[bus.wa1] <= bus.wd1;
            busy_q <= busy_nxt;
        end
    end
`ifdef REGFILE_SB_BYPASS_EN
    logic h0;
    logic h1;
    always_comb begin
        rd_data_c = '0;
        rd_busy_c = '0;
        ra = '0;
        h0 = 1'b0;
        h1 = 1'b0;
        for (int k = 0; k < NUM_RD; k++) begin
            ra = bus.rd_addr[k*AW +: AW];
            h1 = rst_n && w1_ok && bus.wa1 == ra;
            h0 = rst_n && w0_ok && bus.wa0 == ra;
            rd_data_c[k*DATA_W +: DATA_W] = h1 ? bus.wd1 : h0 ? bus.wd0 : regs[ra];
            rd_busy_c[k] = !(h0 || h1) && busy_q[ra];
        end
    end
`else
    always_comb begin
        rd_data_c = '0;
        rd_busy_c = '0;
        ra = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            ra = bus.rd_addr[k*AW +: AW];
            rd_data_c[k*DATA_W +: DATA_W] = regs[ra];
            rd_busy_c[k] = busy_q[ra];
        end
    end
`endif
    assign bus.rd_data = rd_data_c;
    assign bus.rd_busy = rd_busy_c;
    assign bus.busy = busy_q;
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: table-driven vectors with a scoreboard queue, plus hand-written reset sequences.
module tb_regfile_sb;
    localparam int DW = 32;
    localparam int NR = 32;
    localparam int RD = 3;
`ifdef REGFILE_SB_BYPASS_EN
    localparam logic [31:0] BYP4 = 32'hA5A5A5A5;
`else
    localparam logic [31:0] BYP4 = 32'h0;
`endif
    typedef struct {
        logic we0; logic [4:0] wa0; logic [31:0] wd0;
        logic we1; logic [4:0] wa1; logic [31:0] wd1;
        logic iv; logic [4:0] ir;
        logic [4:0] ra0; logic [4:0] ra1; logic [4:0] ra2;
        logic [31:0] e0; logic [31:0] e1; logic [31:0] e2;
        logic [2:0] erb; logic er; logic [31:0] eb;
    } vec_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    vec_t vecs [10];
    vec_t sb [$];
    vec_t e;
    regfile_sb_if #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(RD)) bus ();
    regfile_sb #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(RD)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic drive(input vec_t v);
        bus.we0 = v.we0; bus.wa0 = v.wa0; bus.wd0 = v.wd0;
        bus.we1 = v.we1; bus.wa1 = v.wa1; bus.wd1 = v.wd1;
        bus.iss_valid = v.iv; bus.iss_reg = v.ir;
        bus.rd_addr = {v.ra2, v.ra1, v.ra0};
    endtask
    task automatic chk_reads(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                             input logic [31:0] e2, input logic [2:0] erb);
        chk({tag, " rd0"}, bus.rd_data[31:0], e0);
        chk({tag, " rd1"}, bus.rd_data[63:32], e1);
        chk({tag, " rd2"}, bus.rd_data[95:64], e2);
        chk({tag, " rd_busy"}, {29'd0, bus.rd_busy}, {29'd0, erb});
    endtask
    initial begin
        vecs[0] = '{1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 32'h0};
        vecs[1] = '{1, 0, 32'h1, 0, 0, 0, 0, 0, 5, 0, 5, 32'hDEADBEEF, 0, 32'hDEADBEEF, 3'b000, 0, 32'h0};
        vecs[2] = '{1, 7, 32'h11, 1, 7, 32'h22, 0, 0, 0, 5, 0, 0, 32'hDEADBEEF, 0, 3'b000, 0, 32'h0};
        vecs[3] = '{0, 0, 0, 0, 0, 0, 1, 9, 7, 7, 7, 32'h22, 32'h22, 32'h22, 3'b000, 1, 32'h0};
        vecs[4] = '{0, 0, 0, 0, 0, 0, 1, 9, 9, 0, 7, 0, 0, 32'h22, 3'b001, 0, 32'h200};
        vecs[5] = '{0, 0, 0, 1, 9, 32'h99, 0, 0, 5, 7, 0, 32'hDEADBEEF, 32'h22, 0, 3'b000, 0, 32'h200};
        vecs[6] = '{1, 3, 32'h55, 0, 0, 0, 1, 3, 9, 9, 9, 32'h99, 32'h99, 32'h99, 3'b000, 1, 32'h0};
        vecs[7] = '{0, 0, 0, 0, 0, 0, 1, 0, 3, 9, 0, 32'h55, 32'h99, 0, 3'b001, 1, 32'h8};
        vecs[8] = '{1, 4, 32'hA5A5A5A5, 0, 0, 0, 0, 0, 3, 4, 0, 32'h55, BYP4, 0, 3'b001, 0, 32'h8};
        vecs[9] = '{0, 0, 0, 0, 0, 0, 0, 0, 4, 3, 0, 32'hA5A5A5A5, 32'h55, 0, 3'b010, 0, 32'h8};
        drive('{0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 0, 0, 0, 0, 3'b000, 0, 32'h0});
        #2;
        chk_reads("reset", 0, 0, 0, 3'b000);
        chk("reset busy", bus.busy, 32'h0);
        chk("reset iss_ready", {31'd0, bus.iss_ready}, 32'h1);
        bus.iss_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            sb.push_back(vecs[i]);
            #1;
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL scoreboard empty at row %0d", i);
            end else begin
                e = sb.pop_front();
                chk_reads($sformatf("row%0d", i), e.e0, e.e1, e.e2, e.erb);
                chk($sformatf("row%0d iss_ready", i), {31'd0, bus.iss_ready}, {31'd0, e.er});
                chk($sformatf("row%0d busy", i), bus.busy, e.eb);
            end
        end
        // Fill regs 1..3 with reg 2 pending, then reset mid-cycle without a clock edge.
        @(negedge clk);
        drive('{1, 1, 32'h1, 1, 2, 32'h2, 1, 2, 1, 2, 3, 0, 0, 0, 3'b000, 0, 32'h0});
        #1;
        chk("fill iss_ready", {31'd0, bus.iss_ready}, 32'h1);
        @(negedge clk);
        drive('{0, 0, 0, 0, 0, 0, 1, 3, 1, 2, 3, 0, 0, 0, 3'b000, 0, 32'h0});
        #1;
        chk_reads("pre-reset", 32'h1, 32'h2, 32'h55, 3'b110);
        chk("pre-reset busy", bus.busy, 32'hC);
        chk("pre-reset iss_ready", {31'd0, bus.iss_ready}, 32'h0);
        #1;
        rst_n = 1'b0;
        #1;
        chk_reads("async reset", 0, 0, 0, 3'b000);
        chk("async reset busy", bus.busy, 32'h0);
        chk("async reset iss_ready", {31'd0, bus.iss_ready}, 32'h1);
        // A write held across a clock edge during reset must be discarded.
        drive('{1, 6, 32'h77, 0, 0, 0, 0, 0, 6, 0, 0, 0, 0, 0, 3'b000, 0, 32'h0});
        @(negedge clk);
        rst_n = 1'b1;
        bus.we0 = 1'b0;
        #1;
        chk("reset write discarded", bus.rd_data[31:0], 32'h0);
        @(negedge clk);
        bus.we0 = 1'b1;
        #1;
        @(negedge clk);
        bus.we0 = 1'b0;
        #1;
        chk("post-reset write", bus.rd_data[31:0], 32'h77);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
